// File: rtl/bus_control_sequencer.sv
// bus_control_sequencer: T-state sequencer for the single-bus RA/RB/RZ datapath.
// Takes an op request with a start/busy/done handshake and drives the one-hot
// bus-drive selects and the register load enables. ACCUM repeats its pass
// under a down-counter.
// Optional feature macro: STEP_MODE_EN adds a `step` input. When it is set,
// each T-state holds until a cycle with step=1.
`timescale 1ns/1ps

module bus_control_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] reps,
`ifdef STEP_MODE_EN
    input  logic             step,
`endif
    output logic             RAout,
    output logic             RBout,
    output logic             RZout,
    output logic             RAin,
    output logic             RBin,
    output logic             RZin,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, T0, T1, T2, DONE} state_t;

    localparam logic [1:0] OP_LOAD_A  = 2'b00;
    localparam logic [1:0] OP_MOVE_AB = 2'b01;
    localparam logic [1:0] OP_ADD     = 2'b10;
    localparam logic [1:0] OP_ACCUM   = 2'b11;

    state_t           state, state_nx;
    logic [1:0]       op_q, op_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             adv;
    // {busy, done, RAout, RBout, RZout, RAin, RBin, RZin}
    logic [7:0]       outs_q, outs_nx;

    assign {busy, done, RAout, RBout, RZout, RAin, RBin, RZin} = outs_q;

    // State, latched op, repeat counter and registered strobes
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state  <= IDLE;
            op_q   <= OP_LOAD_A;
            cnt    <= '0;
            outs_q <= '0;
        end else begin
            state  <= state_nx;
            op_q   <= op_nx;
            cnt    <= cnt_nx;
            outs_q <= outs_nx;
        end
    end

    // Next state, and strobes decoded from the state being entered so that they
    // appear as registers aligned with that state
    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        cnt_nx   = cnt;
        outs_nx  = '0;
`ifdef STEP_MODE_EN
        adv = step;
`else
        adv = 1'b1;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    op_nx  = op;
                    cnt_nx = reps;
                    if (op == OP_ACCUM)
                        state_nx = (reps == '0) ? DONE : T1;
                    else
                        state_nx = T0;
                end
            end
            T0: if (adv) state_nx = (op_q == OP_ADD) ? T1 : DONE;
            T1: if (adv) state_nx = T2;
            T2: begin
                if (adv) begin
                    if (op_q == OP_ACCUM) begin
                        // Leaving on count==1 means the counter stops at 0, never wraps
                        cnt_nx   = cnt - CNT_W'(1);
                        state_nx = (cnt > CNT_W'(1)) ? T1 : DONE;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        case (state_nx)
            T0: begin
                outs_nx[7] = 1'b1;
                case (op_nx)
                    OP_LOAD_A:  outs_nx[2] = 1'b1;
                    OP_MOVE_AB: begin outs_nx[5] = 1'b1; outs_nx[1] = 1'b1; end
                    OP_ADD:     outs_nx[2] = 1'b1;
                    default:    outs_nx[7] = 1'b1;
                endcase
            end
            T1: begin
                outs_nx[7] = 1'b1;
                outs_nx[0] = 1'b1;
                if (op_nx == OP_ACCUM) outs_nx[4] = 1'b1;
                else                   outs_nx[5] = 1'b1;
            end
            T2: begin
                outs_nx[7] = 1'b1;
                outs_nx[3] = 1'b1;
                outs_nx[1] = 1'b1;
            end
            DONE:    outs_nx[6] = 1'b1;
            default: outs_nx = '0;
        endcase
    end

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Directed bench for bus_control_sequencer with a small RA/RB/RZ datapath model.
`timescale 1ns/1ps

module tb_bus_control_sequencer;
    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op    = 2'b00;
    logic [3:0] reps  = 4'd0;
`ifdef STEP_MODE_EN
    logic       step  = 1'b1;
`endif
    logic RAout, RBout, RZout, RAin, RBin, RZin, busy, done;

    int total = 0;
    int bad   = 0;

    logic [7:0] RA = 8'd0, RB = 8'd0, RZ = 8'd0;
    logic [7:0] imm = 8'd0, a_opnd = 8'd0;
    logic [7:0] bus;
    logic [7:0] vec;

    always #5 clock = ~clock;

    bus_control_sequencer #(.CNT_W(4)) dut (
        .clock(clock), .clear(clear), .start(start), .op(op), .reps(reps),
`ifdef STEP_MODE_EN
        .step(step),
`endif
        .RAout(RAout), .RBout(RBout), .RZout(RZout),
        .RAin(RAin), .RBin(RBin), .RZin(RZin),
        .busy(busy), .done(done)
    );

    // Datapath: bus mux, RA from immediate, RB from bus, RZ = a_opnd + bus
    assign bus = RAout ? RA : RBout ? RB : RZout ? RZ : 8'h00;
    assign vec = {busy, done, RAout, RBout, RZout, RAin, RBin, RZin};

    always @(posedge clock) begin
        if (RAin) RA <= imm;
        if (RBin) RB <= bus;
        if (RZin) RZ <= a_opnd + bus;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Invariants checked every cycle outside reset
    always @(negedge clock) begin
        if (clear) begin
            chk("bus_onehot", 32'($countones({RAout, RBout, RZout}) <= 1), 32'd1);
            chk("in_wo_busy", 32'((RAin | RBin | RZin) & ~busy), 32'd0);
        end
    end

    // Start accepted at the next edge; returns at the negedge of cycle k+1
    task automatic issue(input logic [1:0] o, input logic [3:0] r);
        @(negedge clock);
        start = 1'b1; op = o; reps = r;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Compare n per-cycle output codes, codes[7:0] being cycle k+1
    task automatic seq(input string tag, input int n, input logic [63:0] codes);
        for (int i = 0; i < n; i++) begin
            chk(tag, 32'(vec), 32'(codes[8*i +: 8]));
            if (i < n - 1) @(negedge clock);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n_busy, n_done, d_cyc;
        logic got;

        // Reset state
        #2 clear = 1'b0;
        @(negedge clock);
        chk("rst_vec", 32'(vec), 32'd0);
        clear = 1'b1;

        // LOAD_A imm=3
        imm = 8'd3;
        issue(2'b00, 4'd0);
        seq("load_a", 3, 64'h00_40_84);
        chk("load_a_ra", 32'(RA), 32'd3);

        // MOVE_AB: RB <= RA
        issue(2'b01, 4'd0);
        seq("move_ab", 3, 64'h00_40_A2);
        chk("move_ab_rb", 32'(RB), 32'd3);

        // ADD A=5 imm=3
        a_opnd = 8'd5; imm = 8'd3;
        issue(2'b10, 4'd0);
        seq("add", 5, 64'h00_40_8A_A1_84);
        chk("add_rz", 32'(RZ), 32'd8);
        chk("add_rb", 32'(RB), 32'd8);

        // ACCUM reps=3 A=2 from RB=8
        a_opnd = 8'd2;
        issue(2'b11, 4'd3);
        seq("accum3", 8, 64'h00_40_8A_91_8A_91_8A_91);
        chk("accum3_rb", 32'(RB), 32'd14);

        // ACCUM reps=0: done only
        issue(2'b11, 4'd0);
        seq("accum0", 2, 64'h00_40);
        chk("accum0_rb", 32'(RB), 32'd14);

        // ACCUM reps=15 A=1: 30 step cycles, no wrap
        a_opnd = 8'd1;
        issue(2'b11, 4'd15);
        n_busy = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (busy) n_busy++;
            if (done) got = 1'b1;
            else @(negedge clock);
        end
        chk("accum15_done", 32'(got), 32'd1);
        chk("accum15_busy", 32'(n_busy), 32'd30);
        chk("accum15_rb", 32'(RB), 32'd29);

        // start during busy ADD is ignored
        a_opnd = 8'd5; imm = 8'd3;
        issue(2'b10, 4'd0);
        n_done = 0; d_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            start = (i == 0);
            op    = 2'b01;
            if (done) begin n_done++; d_cyc = i; end
            @(negedge clock);
        end
        start = 1'b0;
        chk("ign_busy_ndone", 32'(n_done), 32'd1);
        chk("ign_busy_dcyc", 32'(d_cyc), 32'd3);
        chk("ign_busy_rb", 32'(RB), 32'd8);

        // start during DONE is ignored
        imm = 8'd7;
        issue(2'b00, 4'd0);
        @(negedge clock);
        chk("ign_done_vec", 32'(vec), 32'h40);
        start = 1'b1; op = 2'b00;
        @(negedge clock);
        start = 1'b0;
        chk("ign_done_idle", 32'(vec), 32'd0);

        // start held high re-triggers from IDLE
        @(negedge clock);
        start = 1'b1; op = 2'b00;
        @(negedge clock);
        seq("retrigger", 6, 64'h00_40_84_00_40_84);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);

        // clear mid-ADD at T1
        issue(2'b10, 4'd0);
        @(negedge clock);
        chk("pre_rst_t1", 32'(vec), 32'hA1);
        #2 clear = 1'b0;
        #1 chk("mid_rst_vec", 32'(vec), 32'd0);
        @(negedge clock);
        clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("post_rst_idle", 32'(vec), 32'd0);
        end

`ifdef STEP_MODE_EN
        // ADD with step on every 3rd cycle: each T-state lasts 3 cycles
        a_opnd = 8'd5; imm = 8'd3; RB = 8'd0;
        step = 1'b0;
        issue(2'b10, 4'd0);
        for (int i = 0; i < 10; i++) begin
            chk("step_add", 32'(vec),
                (i < 3) ? 32'h84 : (i < 6) ? 32'hA1 : (i < 9) ? 32'h8A : 32'h40);
            step = ((i % 3) == 2);
            @(negedge clock);
        end
        step = 1'b1;
        chk("step_add_rb", 32'(RB), 32'd8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
